// File: rtl/mips_isa_pkg.sv
// Shared MIPS code table for the instruction encoder and the control decoder.
// Holds the 5-bit instruction enum, the OP/FUNC field values, the loader FSM
// state type, and small helpers that pack R-type and I-type words.
package mips_isa_pkg;

  typedef enum logic [4:0] {
    I_SLL, I_SRL, I_SRA, I_SLLV, I_JR, I_SYSCALL, I_ADD, I_ADDU, I_SUB,
    I_AND, I_OR, I_NOR, I_SLT, I_SLTU, I_J, I_JAL, I_BEQ, I_BNE, I_BGTZ,
    I_ADDI, I_ADDIU, I_SLTI, I_SLTIU, I_ANDI, I_ORI, I_LW, I_SH, I_SW
  } instr_e;

  localparam int unsigned NUM_INSTR = 28;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BGTZ  = 6'd7;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SH    = 6'd41;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FUNC_SLL     = 6'd0;
  localparam logic [5:0] FUNC_SRL     = 6'd2;
  localparam logic [5:0] FUNC_SRA     = 6'd3;
  localparam logic [5:0] FUNC_SLLV    = 6'd4;
  localparam logic [5:0] FUNC_JR      = 6'd8;
  localparam logic [5:0] FUNC_SYSCALL = 6'd12;
  localparam logic [5:0] FUNC_ADD     = 6'd32;
  localparam logic [5:0] FUNC_ADDU    = 6'd33;
  localparam logic [5:0] FUNC_SUB     = 6'd34;
  localparam logic [5:0] FUNC_AND     = 6'd36;
  localparam logic [5:0] FUNC_OR      = 6'd37;
  localparam logic [5:0] FUNC_NOR     = 6'd39;
  localparam logic [5:0] FUNC_SLT     = 6'd42;
  localparam logic [5:0] FUNC_SLTU    = 6'd43;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_DONE = 2'd2;
  localparam state_t ST_ERR  = 2'd3;

  function automatic logic [31:0] rtype_word(input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [4:0] rd, input logic [4:0] shamt,
                                             input logic [5:0] func);
    return {OP_RTYPE, rs, rt, rd, shamt, func};
  endfunction

  function automatic logic [31:0] itype_word(input logic [5:0] op, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_word_enc.sv
// Combinational encoder: instruction enum plus symbolic fields -> 32-bit word.
// Ports: op_i (enum, 0..27 legal), rs_i/rt_i/rd_i/shamt_i, imm_i, target_i;
//        word_o (encoded instruction), illegal_o (op_i outside the enum).
module instr_word_enc
  import mips_isa_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (instr_e'(op_i))
      I_SLL:     word_o = rtype_word(rs_i, rt_i, rd_i, shamt_i, FUNC_SLL);
      I_SRL:     word_o = rtype_word(rs_i, rt_i, rd_i, shamt_i, FUNC_SRL);
      I_SRA:     word_o = rtype_word(rs_i, rt_i, rd_i, shamt_i, FUNC_SRA);
      I_SLLV:    word_o = rtype_word(rs_i, rt_i, rd_i, shamt_i, FUNC_SLLV);
      // JR keeps only the source register.
      I_JR:      word_o = rtype_word(rs_i, 5'd0, 5'd0, 5'd0, FUNC_JR);
      // SYSCALL is a fixed word regardless of operands.
      I_SYSCALL: word_o = rtype_word(5'd0, 5'd0, 5'd0, 5'd0, FUNC_SYSCALL);
      I_ADD:     word_o = rtype_word(rs_i, rt_i, rd_i, shamt_i, FUNC_ADD);
      I_ADDU:    word_o = rtype_word(rs_i, rt_i, rd_i, shamt_i, FUNC_ADDU);
      I_SUB:     word_o = rtype_word(rs_i, rt_i, rd_i, shamt_i, FUNC_SUB);
      I_AND:     word_o = rtype_word(rs_i, rt_i, rd_i, shamt_i, FUNC_AND);
      I_OR:      word_o = rtype_word(rs_i, rt_i, rd_i, shamt_i, FUNC_OR);
      I_NOR:     word_o = rtype_word(rs_i, rt_i, rd_i, shamt_i, FUNC_NOR);
      I_SLT:     word_o = rtype_word(rs_i, rt_i, rd_i, shamt_i, FUNC_SLT);
      I_SLTU:    word_o = rtype_word(rs_i, rt_i, rd_i, shamt_i, FUNC_SLTU);
      I_J:       word_o = {OP_J, target_i};
      I_JAL:     word_o = {OP_JAL, target_i};
      I_BEQ:     word_o = itype_word(OP_BEQ, rs_i, rt_i, imm_i);
      I_BNE:     word_o = itype_word(OP_BNE, rs_i, rt_i, imm_i);
      // BGTZ has no second register; its rt slot must be zero.
      I_BGTZ:    word_o = itype_word(OP_BGTZ, rs_i, 5'd0, imm_i);
      I_ADDI:    word_o = itype_word(OP_ADDI, rs_i, rt_i, imm_i);
      I_ADDIU:   word_o = itype_word(OP_ADDIU, rs_i, rt_i, imm_i);
      I_SLTI:    word_o = itype_word(OP_SLTI, rs_i, rt_i, imm_i);
      I_SLTIU:   word_o = itype_word(OP_SLTIU, rs_i, rt_i, imm_i);
      I_ANDI:    word_o = itype_word(OP_ANDI, rs_i, rt_i, imm_i);
      I_ORI:     word_o = itype_word(OP_ORI, rs_i, rt_i, imm_i);
      I_LW:      word_o = itype_word(OP_LW, rs_i, rt_i, imm_i);
      I_SH:      word_o = itype_word(OP_SH, rs_i, rt_i, imm_i);
      I_SW:      word_o = itype_word(OP_SW, rs_i, rt_i, imm_i);
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded MIPS words into instruction memory from BASE_ADDR upward.
// Ports: clk, rst (sync, active-high); start pulse; in_valid/in_ready beat
//        handshake with in_op/in_rs/in_rt/in_rd/in_shamt/in_imm/in_target/
//        in_last; mem_we/mem_addr/mem_wdata write port; busy/done/err status;
//        count of words written this session.
//
// state   | meaning
// IDLE    | waiting for start after reset
// LOAD    | accepting beats, one registered write per legal beat
// DONE    | last beat written, waiting for start
// ERR     | illegal op or memory full, waiting for start
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic [31:0]         enc_word;
  logic                enc_illegal;
  logic                accept;
  logic                full;

  instr_word_enc u_enc (
    .op_i      (in_op),
    .rs_i      (in_rs),
    .rt_i      (in_rt),
    .rd_i      (in_rd),
    .shamt_i   (in_shamt),
    .imm_i     (in_imm),
    .target_i  (in_target),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  assign accept = (state_q == ST_LOAD) && in_valid;
  // count never exceeds DEPTH, so its top bit alone means "memory full".
  assign full   = count_q[ADDR_W];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          if (enc_illegal || full) begin
            state_d = ST_ERR;
          end else begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = enc_word;
            ptr_d   = ptr_q + ADDR_W'(1);
            count_d = count_q + (ADDR_W+1)'(1);
            if (in_last) state_d = ST_DONE;
          end
        end
      end
      default: begin
        if (start) begin
          state_d = ST_LOAD;
          ptr_d   = BASE_PTR;
          count_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= BASE_PTR;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_LOAD);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_ERR);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Assembles MIPS instruction words from symbolic fields and streams them into instruction memory. It covers the same 28-instruction subset that the core's control decoder recognises, and is the encoding end of the OP/FUNC format. It sits between the testbench/boot loader and the instruction-memory write port. Operands arrive over a valid/ready handshake, and encoded words are written at consecutive addresses from BASE_ADDR.

## Interface
- ADDR_W, 10: instruction-memory word-address width; DEPTH = 2^ADDR_W words.
- BASE_ADDR, 0: first word address written after start.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins a load session; honoured in IDLE, DONE and ERR only.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_op  in  5  instruction enum, 0..27 legal.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_imm  in  16  I-type immediate, raw bits.
- in_target  in  26  J-type word target.
- in_last  in  1  marks the final beat of the program.
- mem_we  out  1  write strobe to instruction memory.
- mem_addr  out  ADDR_W  write word address.
- mem_wdata  out  32  encoded instruction.
- busy  out  1  state is LOAD.
- done  out  1  state is DONE.
- err  out  1  state is ERR.
- count  out  ADDR_W+1  words written this session.

## Operation
- FSM states: IDLE, LOAD, DONE, ERR. Reset state is IDLE.
- IDLE/DONE/ERR + start → LOAD. On that edge, count is set to 0 and the write pointer to BASE_ADDR.
- A beat is accepted when in_ready && in_valid. in_ready = (state == LOAD).
- LOAD, accepted beat, legal op, count < DEPTH:
  - Encode the beat and register it into mem_wdata/mem_addr with mem_we = 1 on the next cycle.
  - Increment the pointer and count.
  - Pointer wraps modulo DEPTH, so BASE_ADDR need not be 0.
- Accepted beat with op ≥ 28, or with count == DEPTH: → ERR. No write occurs and count is unchanged.
- Accepted beat with legal op and in_last: the write proceeds and state → DONE on the same edge.
- start while in LOAD is ignored.
- Encoding:
  - R-type: {6'd0, rs, rt, rd, shamt, func}. func values: SLL 0, SRL 2, SRA 3, SLLV 4, JR 8, SYSCALL 12, ADD 32, ADDU 33, SUB 34, AND 36, OR 37, NOR 39, SLT 42, SLTU 43.
  - JR: only the rs field is kept; other fields are 0.
  - SYSCALL: the word is 32'h0000000C; all operands are ignored.
  - I-type: {op, rs, rt, imm}. op values: BEQ 4, BNE 5, BGTZ 7, ADDI 8, ADDIU 9, SLTI 10, SLTIU 11, ANDI 12, ORI 13, LW 35, SH 41, SW 43.
  - BGTZ: rt is forced to 0.
  - J-type: {op, target}. op values: J 2, JAL 3.
- Enum order: SLL, SRL, SRA, SLLV, JR, SYSCALL, ADD, ADDU, SUB, AND, OR, NOR, SLT, SLTU, J, JAL, BEQ, BNE, BGTZ, ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, LW, SH, SW (0..27).

## Timing
- Reset values: mem_we 0, mem_addr 0, mem_wdata 0, count 0, in_ready 0, busy 0, done 0, err 0.
- Latency from accept edge to mem_we is 1 cycle. Throughput is 1 word per cycle with in_valid held high.
- mem_we is high for exactly one cycle per accepted legal beat.
- Final write: its mem_we cycle coincides with the first cycle of done = 1.
- rst in any state returns all outputs to their reset values on that edge and drops any pending write.
- start and an accepted beat cannot coincide, because in_ready = 0 outside LOAD.
- The write that completes the beat accepted at count == DEPTH-1 still occurs. The next beat goes to ERR.

## Structure
- Package mips_isa_pkg holds:
  - the 5-bit instruction enum;
  - the OP and FUNC localparams;
  - the FSM state typedef.
- These are shared with the control decoder so that both ends use one code table.
- One sub-module is natural: instr_word_enc, a purely combinational enum+fields → 32-bit word encoder with an illegal flag. The FSM, pointer and output register live in instr_encoder.

## Test plan
- start, then beat ADD rs=1 rt=2 rd=3 → next cycle mem_we=1, mem_addr=0, mem_wdata=32'h00221820, count=1.
- Back-to-back beats ADDI rt=8 rs=0 imm=16'hFFFF; J target=26'h100; SW rs=29 rt=31 imm=4 with in_last → words 2008FFFF, 08000100, AFBF0004 at addresses 0, 1, 2 on consecutive cycles; done=1 with the third write.
- SYSCALL with all operands at 5'h1F → 0000000C. JR rs=31 rd=5 → 03E00008.
- in_op=30 mid-stream → err=1, no mem_we, count held; a new start → LOAD, count=0.
- ADDR_W=2, BASE_ADDR=3: four beats write addresses 3, 0, 1, 2. The fifth beat → ERR with no write.
- rst asserted the cycle after an accept → mem_we stays 0 and all outputs read reset values.
